// File: rtl/demux1to4_deser.sv
// 1-to-4 serial demultiplexer: routes each valid input bit to one of four
// per-channel deserializers and presents completed words with a valid/ready handshake.
module demux1to4_deser #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 In,
  input  logic                 In_valid,
  input  logic [1:0]           sel,
  output logic [4*WIDTH-1:0]   Out,
  output logic [3:0]           Out_valid,
  input  logic [3:0]           Out_ready,
  output logic [3:0]           overrun,
  input  logic                 clr_overrun
);

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [NCH-1:0][WIDTH-1:0] shreg_q, shreg_d;
  logic [NCH-1:0][WIDTH-1:0] word_q, word_d;
  logic [NCH-1:0][CW-1:0]    cnt_q, cnt_d;
  logic [NCH-1:0]            vld_q, vld_d;
  logic [NCH-1:0]            ovr_q, ovr_d;
  // Low for the first edge after reset release so that edge samples nothing
  logic                      armed_q;

  // Next-state: per-channel shift/complete, handshake and sticky overrun
  always_comb begin
    shreg_d = shreg_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    ovr_d   = ovr_q;
    if (armed_q) begin
      if (clr_overrun) ovr_d = '0;
      for (int k = 0; k < NCH; k++) begin
        if (vld_q[k] && Out_ready[k]) vld_d[k] = 1'b0;
        if (In_valid && (sel == 2'(k))) begin
          shreg_d[k] = {shreg_q[k][WIDTH-2:0], In};
          if (cnt_q[k] == CW'(WIDTH - 1)) begin
            // Completion wins over accept; overrun only if the old word was not taken
            cnt_d[k]  = '0;
            word_d[k] = {shreg_q[k][WIDTH-2:0], In};
            vld_d[k]  = 1'b1;
            if (vld_q[k] && !Out_ready[k]) ovr_d[k] = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] + CW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      vld_q   <= '0;
      ovr_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
      armed_q <= 1'b1;
    end
  end

  assign Out       = word_q;
  assign Out_valid = vld_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_demux1to4_deser.sv
// Self-checking bench for demux1to4_deser (WIDTH=8) using a bit-level
// reference model that queues expected words for comparison on completion.
module tb_demux1to4_deser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        In;
  logic        In_valid;
  logic [1:0]  sel;
  logic [31:0] Out;
  logic [3:0]  Out_valid;
  logic [3:0]  Out_ready;
  logic [3:0]  overrun;
  logic        clr_overrun;

  demux1to4_deser #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .In(In), .In_valid(In_valid), .sel(sel),
    .Out(Out), .Out_valid(Out_valid), .Out_ready(Out_ready),
    .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {int ch; logic [7:0] w;} exp_t;
  exp_t       sbq[$];
  logic [7:0] msh[4];
  int         mcnt[4];
  int         checks = 0;
  int         errors = 0;

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin msh[c] = '0; mcnt[c] = 0; end
    sbq.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      In = 1'($urandom); sel = 2'($urandom);
    end
  endtask

  // Drive one valid bit for one edge and advance the reference model
  task automatic send_bit(input int ch, input logic b);
    In_valid = 1'b1; sel = 2'(ch); In = b;
    @(posedge clk); #1;
    In_valid = 1'b0; sel = 2'($urandom); In = 1'($urandom);
    msh[ch] = {msh[ch][6:0], b};
    mcnt[ch]++;
    if (mcnt[ch] == 8) begin
      mcnt[ch] = 0;
      sbq.push_back('{ch, msh[ch]});
    end
  endtask

  task automatic send_word(input int ch, input logic [7:0] w, input logic [3:0] rdy_last,
                           input logic clr_last);
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) begin Out_ready = rdy_last; clr_overrun = clr_last; end
      send_bit(ch, w[i]);
      Out_ready = '0; clr_overrun = 1'b0;
    end
  endtask

  task automatic check_sb(input string name);
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if (Out[e.ch*8 +: 8] !== e.w || Out_valid[e.ch] !== 1'b1) begin
        errors++;
        $display("FAIL %s ch%0d: Out=%h valid=%b, expected Out=%h valid=1",
                 name, e.ch, Out[e.ch*8 +: 8], Out_valid[e.ch], e.w);
      end
    end
  endtask

  task automatic accept(input logic [3:0] m);
    Out_ready = m; idle(1); Out_ready = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; In = 1'b0; In_valid = 1'b0; sel = '0; Out_ready = '0; clr_overrun = 1'b0;
    model_reset();
    #12;
    checks++;
    if (Out !== '0 || Out_valid !== '0 || overrun !== '0) begin
      errors++;
      $display("FAIL reset: Out=%h valid=%b ovr=%b, expected all 0", Out, Out_valid, overrun);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    idle(2);
    checks++;
    if (Out_valid !== '0) begin
      errors++; $display("FAIL reset_idle: valid=%b, expected 0000", Out_valid);
    end
  endtask

  task automatic test_single_word();
    send_word(2, 8'hA5, 4'b0000, 1'b0);
    check_sb("single");
    checks++;
    if (Out_valid !== 4'b0100) begin
      errors++; $display("FAIL single_valid: valid=%b, expected 0100", Out_valid);
    end
    accept(4'b0100);
    checks++;
    if (Out_valid !== 4'b0000 || Out[23:16] !== 8'hA5) begin
      errors++;
      $display("FAIL single_accept: valid=%b Out=%h, expected 0000 a5", Out_valid, Out[23:16]);
    end
    Out_ready = 4'b0100; idle(2); Out_ready = '0;
    checks++;
    if (Out_valid !== 4'b0000) begin
      errors++; $display("FAIL ready_no_effect: valid=%b, expected 0000", Out_valid);
    end
  endtask

  task automatic test_interleave();
    for (int i = 0; i < 8; i++) begin
      send_bit(0, 1'b1);
      check_sb("interleave_ch0");
      if (i == 7) begin
        checks++;
        if (Out_valid[1] !== 1'b0) begin
          errors++; $display("FAIL interleave_early: valid1=%b, expected 0", Out_valid[1]);
        end
      end
      send_bit(1, 1'b0);
      check_sb("interleave_ch1");
    end
    checks++;
    if (Out_valid !== 4'b0011 || Out[15:0] !== 16'h00FF) begin
      errors++;
      $display("FAIL interleave_final: valid=%b Out=%h, expected 0011 00ff", Out_valid, Out[15:0]);
    end
    accept(4'b0011);
  endtask

  task automatic test_overrun();
    send_word(3, 8'h11, 4'b0000, 1'b0);
    check_sb("ovr_first");
    send_word(3, 8'h22, 4'b0000, 1'b0);
    check_sb("ovr_second");
    checks++;
    if (overrun !== 4'b1000) begin
      errors++; $display("FAIL ovr_set: ovr=%b, expected 1000", overrun);
    end
    clr_overrun = 1'b1; idle(1); clr_overrun = 1'b0;
    checks++;
    if (overrun !== 4'b0000 || Out_valid[3] !== 1'b1 || Out[31:24] !== 8'h22) begin
      errors++;
      $display("FAIL ovr_clear: ovr=%b valid3=%b Out=%h, expected 0000 1 22",
               overrun, Out_valid[3], Out[31:24]);
    end
    // Clear and set on the same edge: set wins
    send_word(3, 8'h44, 4'b0000, 1'b1);
    check_sb("ovr_clrset");
    checks++;
    if (overrun !== 4'b1000) begin
      errors++; $display("FAIL ovr_set_wins: ovr=%b, expected 1000", overrun);
    end
    clr_overrun = 1'b1; accept(4'b1000); clr_overrun = 1'b0;
  endtask

  task automatic test_back_to_back();
    send_word(0, 8'h5A, 4'b0000, 1'b0);
    check_sb("b2b_first");
    send_word(0, 8'hC3, 4'b0001, 1'b0);
    check_sb("b2b_second");
    checks++;
    if (overrun !== 4'b0000) begin
      errors++; $display("FAIL b2b_ovr: ovr=%b, expected 0000", overrun);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] words[2];
    words[0] = 8'h96; words[1] = 8'h0F;
    for (int n = 0; n < 2; n++) begin
      for (int i = 7; i >= 0; i--) begin
        send_bit(2, words[n][i]);
        if (i > 0) idle(int'($urandom_range(5, 0)));
        if (i == 1) begin
          checks++;
          if (Out_valid[2] !== 1'b0) begin
            errors++; $display("FAIL gaps_early: valid2=%b, expected 0", Out_valid[2]);
          end
        end
      end
      check_sb("gaps_word");
      accept(4'b0100);
    end
  endtask

  task automatic test_reset_midword();
    send_bit(1, 1'b1); send_bit(1, 1'b0); send_bit(1, 1'b1); send_bit(1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (Out !== '0 || Out_valid !== '0 || overrun !== '0) begin
      errors++;
      $display("FAIL async_reset: Out=%h valid=%b ovr=%b, expected all 0", Out, Out_valid, overrun);
    end
    model_reset();
    @(posedge clk); #1; rst_n = 1'b1;
    idle(2);
    send_word(1, 8'h3C, 4'b0000, 1'b0);
    check_sb("post_reset");
    checks++;
    if (Out_valid !== 4'b0010 || Out[15:8] !== 8'h3C) begin
      errors++;
      $display("FAIL post_reset_word: valid=%b Out=%h, expected 0010 3c", Out_valid, Out[15:8]);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_interleave();
    test_overrun();
    test_back_to_back();
    test_gaps();
    test_reset_midword();
    checks++;
    if (sbq.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d left, expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
